pc_gen: RTL and testbench

Parametrised program-counter generator at the front of the fetch stage. It replaces the bare PC register with these additions:
- a valid/ready handshake toward the IFU;
- prioritised redirect sources (trap, then branch/jump);
- target alignment checking;
- a halt state;
- a fetch-issue counter.

It drives the address the IFU fetches and receives redirects from the EXU and the trap/CSR unit.

---
 rtl/pc_gen.sv | 186 ++++++++++++++++++
 tb/tb_pc_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- program-counter generator at the front of the fetch stage.
//
// Holds the current fetch address and offers it to the IFU through a
// valid/ready handshake. Each cycle in RUN the next PC is chosen by priority:
// halt (hold), trap, branch/jump redirect, sequential step on an accepted
// fetch, or hold. A redirect target is loaded with its sub-instruction offset
// bits cleared. A one-cycle misalign pulse is raised if any of those bits
// were set. A free-running counter records completed fetch handshakes.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   out_valid       out_pc is a fetch request (registered)
//   out_ready       IFU accepts the request this cycle
//   out_pc          current fetch address (registered)
//   out_snpc        out_pc + INST_BYTES, combinational, wraps modulo 2^XLEN
//   redirect_valid  branch/jump redirect from the EXU
//   redirect_pc     branch/jump target
//   trap_valid      trap or xRET redirect, beats redirect_valid
//   trap_pc         trap vector or return address
//   halt            stop fetching, sticky until reset
//   flush           one-cycle pulse after any accepted redirect (registered)
//   misalign        one-cycle pulse after a target with nonzero offset bits
//   fetch_cnt       handshakes completed since reset, wraps silently
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int                XLEN       = 32,
    parameter logic [XLEN-1:0]   RST_ADDR   = 32'h8000_0000,
    parameter int                INST_BYTES = 4,
    parameter int                CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_snpc,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              trap_valid,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              halt,
    output logic              flush,
    output logic              misalign,
    output logic [CNT_W-1:0]  fetch_cnt
);

    // Two-bit state encoding; the unused code falls back to BOOT.
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Sequential step and the mask of offset bits below one instruction.
    localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0]  OFF_MASK = XLEN'(INST_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic              valid_q;
    logic              valid_d;
    logic              flush_q;
    logic              flush_d;
    logic              misalign_q;
    logic              misalign_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              fire_s;
    logic              redir_any_s;
    logic [XLEN-1:0]   target_s;
    logic [XLEN-1:0]   target_aligned_s;
    logic              target_off_s;
    logic [XLEN-1:0]   snpc_s;

    // Handshake, redirect source selection (trap beats branch) and alignment.
    always_comb begin
        fire_s           = valid_q & out_ready;
        redir_any_s      = trap_valid | redirect_valid;
        if (trap_valid) begin
            target_s = trap_pc;
        end else begin
            target_s = redirect_pc;
        end
        target_aligned_s = target_s & ~OFF_MASK;
        target_off_s     = |(target_s & OFF_MASK);
        snpc_s           = pc_q + PC_STEP;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: BOOT lasts exactly one edge, HALT is left only by reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Next values of the PC, pulses and counter; only RUN does anything.
    always_comb begin
        pc_d       = pc_q;
        flush_d    = 1'b0;
        misalign_d = 1'b0;
        cnt_d      = cnt_q;
        valid_d    = (state_d == ST_RUN);
        case (state_q)
            ST_RUN: begin
                // A fire counts even when a redirect or halt lands with it.
                if (fire_s) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
                if (halt) begin
                    pc_d = pc_q;
                end else if (redir_any_s) begin
                    // Un-fired request is dropped in favour of the target.
                    pc_d       = target_aligned_s;
                    flush_d    = 1'b1;
                    misalign_d = target_off_s;
                end else if (fire_s) begin
                    pc_d = snpc_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RST_ADDR;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    // Output drive.
    always_comb begin
        out_valid = valid_q;
        out_pc    = pc_q;
        out_snpc  = snpc_s;
        flush     = flush_q;
        misalign  = misalign_q;
        fetch_cnt = cnt_q;
    end

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- directed bench for pc_gen with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are checked there,
// well before the next edge.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_snpc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        halt;
    logic        flush;
    logic        misalign;
    logic [31:0] fetch_cnt;

    int vecs;
    int errs;

    pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_snpc       (out_snpc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .halt           (halt),
        .flush          (flush),
        .misalign       (misalign),
        .fetch_cnt      (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the whole visible state in one go.
    task automatic chk_all(input string tag, input logic v, input logic [31:0] pc,
                           input logic fl, input logic ma, input logic [31:0] cnt);
        chk({tag, ".valid"},    {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".pc"},       out_pc,             pc);
        chk({tag, ".flush"},    {31'd0, flush},     {31'd0, fl});
        chk({tag, ".misalign"}, {31'd0, misalign},  {31'd0, ma});
        chk({tag, ".cnt"},      fetch_cnt,          cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs           = 0;
        errs           = 0;
        rst            = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        trap_valid     = 1'b0;
        trap_pc        = 32'h0;
        halt           = 1'b0;

        // Reset held.
        #12;
        chk_all("reset", 1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'd0);

        // Release away from an edge; still BOOT until the next edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all("boot", 1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'd0);

        // First edge: RUN, request at reset address.
        step();
        chk_all("run0", 1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'd0);
        chk("run0.snpc", out_snpc, 32'h8000_0004);
        step();
        chk_all("seq1", 1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'd1);
        step();
        chk_all("seq2", 1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'd2);
        step();
        chk_all("seq3", 1'b1, 32'h8000_000C, 1'b0, 1'b0, 32'd3);
        step();
        chk_all("seq4", 1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'd4);

        // Backpressure for three cycles.
        out_ready = 1'b0;
        step();
        chk_all("stall1", 1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'd4);
        step();
        chk_all("stall2", 1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'd4);
        step();
        chk_all("stall3", 1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'd4);
        out_ready = 1'b1;
        step();
        chk_all("resume", 1'b1, 32'h8000_0014, 1'b0, 1'b0, 32'd5);

        // Redirect while stalled: counter unchanged.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        chk_all("redir", 1'b1, 32'h8000_0100, 1'b1, 1'b0, 32'd5);
        redirect_valid = 1'b0;
        step();
        chk_all("redir_after", 1'b1, 32'h8000_0100, 1'b0, 1'b0, 32'd5);

        // Trap and redirect together: trap wins.
        trap_valid     = 1'b1;
        trap_pc        = 32'h8000_0200;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        chk_all("trap_wins", 1'b1, 32'h8000_0200, 1'b1, 1'b0, 32'd5);
        trap_valid     = 1'b0;
        redirect_valid = 1'b0;
        step();
        chk_all("trap_after", 1'b1, 32'h8000_0200, 1'b0, 1'b0, 32'd5);

        // Misaligned target gets low bits cleared.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0106;
        step();
        chk_all("misal", 1'b1, 32'h8000_0104, 1'b1, 1'b1, 32'd5);
        redirect_valid = 1'b0;
        step();
        chk_all("misal_after", 1'b1, 32'h8000_0104, 1'b0, 1'b0, 32'd5);

        // Trap to the top of the address space; snpc wraps.
        trap_valid = 1'b1;
        trap_pc    = 32'hFFFF_FFFC;
        step();
        chk_all("top", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd5);
        chk("top.snpc", out_snpc, 32'h0000_0000);
        trap_valid = 1'b0;
        out_ready  = 1'b1;
        step();
        chk_all("wrap", 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'd6);
        chk("wrap.snpc", out_snpc, 32'h0000_0004);

        // Redirect coinciding with a fire still counts the fire.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0020;
        step();
        chk_all("redir_fire", 1'b1, 32'h8000_0020, 1'b1, 1'b0, 32'd7);
        redirect_valid = 1'b0;

        // Halt with a fire: counts once, holds PC, clears flush.
        halt = 1'b1;
        step();
        chk_all("halt", 1'b0, 32'h8000_0020, 1'b0, 1'b0, 32'd8);
        halt = 1'b0;

        // Everything ignored in HALT, including a misaligned trap.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        trap_valid     = 1'b1;
        trap_pc        = 32'h8000_0402;
        step();
        chk_all("halt_ign", 1'b0, 32'h8000_0020, 1'b0, 1'b0, 32'd8);
        step();
        chk_all("halt_ign2", 1'b0, 32'h8000_0020, 1'b0, 1'b0, 32'd8);

        // Asynchronous reset mid-cycle, before the next edge.
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'd0);

        // Pending redirect is lost; restart from reset address.
        trap_valid     = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk_all("restart", 1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'd0);
        step();
        chk_all("restart1", 1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
